// File: rtl/param_queue.sv
// Parametrised show-ahead FIFO with mark/rewind replay and sticky error flags.
// o_data is a registered copy of the head entry; all flags derive from registers.
`ifndef BIT_P_GROUP
`define BIT_P_GROUP 8
`endif
`ifndef QUEUE_SIZE
`define QUEUE_SIZE 16
`endif

module param_queue #(
    parameter int WIDTH    = `BIT_P_GROUP,
    parameter int DEPTH    = `QUEUE_SIZE,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_init,
    input  logic                   i_store,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_take,
    input  logic                   i_mark,
    input  logic                   i_rewind,
    input  logic                   i_release,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_almost_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    output logic                   o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    r_ptr, w_ptr, mark_ptr;
    logic             mark_active;

    logic [PW-1:0]    base, used;
    logic             rewind_ok, take_ok, store_ok;
    logic             ovf_set, unf_set;
    logic [PW-1:0]    r_next, w_next, mark_next;
    logic             mark_active_next;
    logic [WIDTH-1:0] data_next;

    // Store/take are single-cycle requests, no backpressure: a request is either
    // accepted on the edge it is sampled or dropped and recorded in a sticky flag.
    assign base          = mark_active ? mark_ptr : r_ptr;
    assign used          = w_ptr - base;
    assign o_count       = w_ptr - r_ptr;
    assign o_valid       = (w_ptr != r_ptr);
    assign o_full        = (used == DEPTH_P);
    assign o_almost_full = (used >= AF_P);

    always_comb begin
        rewind_ok = i_rewind & mark_active;
        take_ok   = i_take & o_valid & ~rewind_ok;
        unf_set   = i_take & ~o_valid & ~rewind_ok;
        // A take only frees its slot when no mark (old or new) protects it.
        store_ok  = i_store & ((used < DEPTH_P) | (take_ok & ~mark_active & ~i_mark));
        ovf_set   = i_store & ~store_ok;

        r_next = r_ptr;
        if (rewind_ok)
            r_next = mark_ptr;
        else if (take_ok)
            r_next = r_ptr + PW'(1);

        w_next           = store_ok ? (w_ptr + PW'(1)) : w_ptr;
        mark_next        = rewind_ok ? mark_ptr : r_ptr;
        mark_active_next = i_mark | (mark_active & ~i_release);

        // Bypass when the new head is the slot being written this cycle.
        if (store_ok && (r_next == w_ptr))
            data_next = i_data;
        else
            data_next = mem[r_next[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (store_ok)
            mem[w_ptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst || i_init) begin
            r_ptr       <= '0;
            w_ptr       <= '0;
            mark_ptr    <= '0;
            mark_active <= 1'b0;
            o_data      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            r_ptr       <= r_next;
            w_ptr       <= w_next;
            mark_active <= mark_active_next;
            o_data      <= data_next;
            if (i_mark)
                mark_ptr <= mark_next;
            if (ovf_set)
                o_overflow <= 1'b1;
            if (unf_set)
                o_underflow <= 1'b1;
        end
    end
endmodule
